line_refill_engine: RTL and testbench
=====================================

Name: line_refill_engine

Overview:
- Miss-service stage directly downstream of the direct-mapped data cache.
- Accepts the cache's line-fetch request (memRead) and reads the four words of the aligned block from word-wide main memory, one word at a time.
- Assembles the words into a 128-bit line and presents it to the cache's block-write data input with a one-cycle valid strobe.
- Provides a per-word response timeout and a refill counter.

Parameters:
ADDR_W, 15, word address width (3-bit tag, 10-bit index, 2-bit offset)
WORD_W, 32, memory word width
WORDS, 4, words per line; power of two
TIMEOUT, 16, WAIT cycles without mem_rvalid before abort; 1..255

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req  input  1  line-fetch request from cache (level); sampled only in IDLE
req_addr  input  ADDR_W  miss address; offset bits ignored
busy  output  1  high in every state except IDLE
mem_rd  output  1  single-cycle read strobe to memory
mem_addr  output  ADDR_W  word address for current read
mem_rdata  input  WORD_W  memory read data
mem_rvalid  input  1  mem_rdata valid this cycle
line_data  output  WORDS*WORD_W  assembled line; word k at bits [k*WORD_W +: WORD_W]
line_valid  output  1  one-cycle strobe, line_data complete
line_err  output  1  one-cycle strobe, refill aborted on timeout
refill_count  output  16  completed refills, saturating at 16'hFFFF

Behaviour:
- Reset: rst=1 forces IDLE immediately. busy, mem_rd, line_valid and line_err are 0. mem_addr, line_data, refill_count, word index and timeout counter are 0.
- Reset mid-refill: the refill is abandoned, with no line_valid and no line_err. Post-reset behaviour is identical to power-up.
- State machine, all transitions on posedge clk:
  - IDLE: if req=1, latch base = {req_addr[ADDR_W-1:2], 2'b00}, clear word index k=0, go ISSUE. mem_rvalid is ignored.
  - ISSUE: mem_rd=1 for exactly this cycle, mem_addr = base + k. Clear timeout counter. Go WAIT unconditionally.
  - WAIT: mem_rd=0; mem_addr holds.
    - If mem_rvalid=1: write mem_rdata into line_data word k. If k==WORDS-1 go DONE, else k=k+1 and go ISSUE.
    - Otherwise increment timeout counter. When it reaches TIMEOUT (TIMEOUT consecutive WAIT cycles without rvalid), go ERR.
  - DONE: line_valid=1 for this cycle only. refill_count increments unless already 16'hFFFF. Go IDLE.
  - ERR: line_err=1 for this cycle only. refill_count unchanged; line_data keeps the partially written words. Go IDLE.
- mem_rvalid is honoured only in WAIT. rvalid in ISSUE, DONE, ERR or IDLE is dropped.
- Latency: with zero-wait memory (rvalid in the first WAIT cycle), line_valid is high in the 9th cycle after the edge that samples req. Each memory wait cycle adds 1.
- req held high through DONE is re-sampled in the following IDLE cycle and starts a new refill. The cache must drop req on line_valid.
- req and req_addr changes while busy=1 are ignored. base is fixed for the whole refill.
- line_data holds its value after DONE until the next refill overwrites word 0.
- Address arithmetic is modulo 2^ADDR_W. Base is aligned, so base+k never carries into the index or tag.

Test Plan:
- Basic refill: req=1 with req_addr=15'h1236 and zero-wait memory returning 32'hA0+addr. Required: mem_addr sequence 1234, 1235, 1236, 1237, one mem_rd per word. line_data = {000012D7, 000012D6, 000012D5, 000012D4}. line_valid pulses in cycle 9. refill_count=1.
- Wait states: memory delays each rvalid 3 cycles. Required: line_valid at cycle 21, same data, busy high throughout.
- Timeout: memory never responds to the third read (k=2), TIMEOUT=16. Required: line_err pulses exactly 16 WAIT cycles after that mem_rd. No line_valid, refill_count unchanged, busy=0 next cycle.
- Ignored inputs: spurious mem_rvalid in IDLE and ISSUE, and req_addr changing mid-refill. Required: no capture, and mem_addr stays within the originally latched block.
- Reset mid-operation: rst asserted between clock edges during the WAIT for word 1. Required: mem_rd, busy, line_valid and refill_count read 0 immediately. A new req afterwards completes normally.
- Saturation and back-to-back: preload refill_count to FFFE via 2 refills with req held high. Required: the second refill starts in the cycle after DONE, and the count stops at FFFF.

Source files
------------

// File: rtl/line_refill_engine.sv
// Line refill engine: on a cache miss, fetches the WORDS words of the aligned
// block from word-wide memory one at a time. It assembles them into a line and
// strobes line_valid. If memory stops responding, it aborts with line_err.
module line_refill_engine #(
  parameter int ADDR_W  = 15,
  parameter int WORD_W  = 32,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    busy,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid,
  output logic [WORDS*WORD_W-1:0] line_data,
  output logic                    line_valid,
  output logic                    line_err,
  output logic [15:0]             refill_count
);

  // Offset field width; the block base always has these bits cleared.
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [KW-1:0]           k_q, k_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [WORDS*WORD_W-1:0] line_q, line_d;
  logic [15:0]             refill_count_q, refill_count_d;
  logic                    busy_q, busy_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    line_valid_q, line_valid_d;
  logic                    line_err_q, line_err_d;

  // The offset bits of the miss address carry no information for a line fetch.
  logic unused_offset;
  assign unused_offset = ^req_addr[KW-1:0];

  // Next-state logic. Outputs are decoded from the next state so that they come
  // straight from flops and line up with the state they describe.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    k_d            = k_q;
    tmo_d          = tmo_q;
    line_d         = line_q;
    refill_count_d = refill_count_q;
    mem_addr_d     = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d  = {req_addr[ADDR_W-1:KW], {KW{1'b0}}};
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          line_d[k_q*WORD_W +: WORD_W] = mem_rdata;
          if (k_q == KW'(WORDS-1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_ISSUE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          // tmo_q counts the silent WAIT cycles already spent; this one is the last.
          if (tmo_q == 8'(TIMEOUT-1)) state_d = S_ERR;
        end
      end
      S_DONE: begin
        if (refill_count_q != 16'hFFFF) refill_count_d = refill_count_q + 16'd1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        // Partially written words stay in the line buffer.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Base is aligned, so base+k is just the offset field replaced by k.
    if (state_d == S_ISSUE) mem_addr_d = {base_d[ADDR_W-1:KW], k_d};
    busy_d       = (state_d != S_IDLE);
    mem_rd_d     = (state_d == S_ISSUE);
    line_valid_d = (state_d == S_DONE);
    line_err_d   = (state_d == S_ERR);
  end

  // State and registered outputs; reset abandons any refill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      mem_addr_q     <= '0;
      k_q            <= '0;
      tmo_q          <= '0;
      line_q         <= '0;
      refill_count_q <= '0;
      busy_q         <= 1'b0;
      mem_rd_q       <= 1'b0;
      line_valid_q   <= 1'b0;
      line_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      mem_addr_q     <= mem_addr_d;
      k_q            <= k_d;
      tmo_q          <= tmo_d;
      line_q         <= line_d;
      refill_count_q <= refill_count_d;
      busy_q         <= busy_d;
      mem_rd_q       <= mem_rd_d;
      line_valid_q   <= line_valid_d;
      line_err_q     <= line_err_d;
    end
  end

  assign busy         = busy_q;
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign line_data    = line_q;
  assign line_valid   = line_valid_q;
  assign line_err     = line_err_q;
  assign refill_count = refill_count_q;

endmodule

// File: tb/tb_line_refill_engine.sv
// Bench for line_refill_engine: a memory model answers reads with 32'hA0+addr
// after a programmable delay; addresses and lines are scoreboarded.
module tb_line_refill_engine;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [14:0]   req_addr = '0;
  logic          busy, mem_rd, line_valid, line_err;
  logic [14:0]   mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [127:0]  line_data;
  logic [15:0]   refill_count;

  line_refill_engine #(.ADDR_W(15), .WORD_W(32), .WORDS(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .line_data(line_data), .line_valid(line_valid),
    .line_err(line_err), .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    int          delay;
    logic [14:0] exp_base;
    int          exp_lat;
    bit          spur;
  } vec_t;

  vec_t         vecs[4];
  logic [14:0]  exp_addr_q[$];
  logic [127:0] exp_line_q[$];

  int n_chk = 0, n_fail = 0, cyc_n = 0;
  int lv_seen = 0, lv_t = 0, err_seen = 0, err_t = 0, rd_seen = 0, last_rd_t = 0;
  int mem_delay = 0, pend_cnt = 0;
  bit pend = 0, drop_en = 0, spur_idle = 0, spur_issue = 0;
  logic [1:0]  drop_k = 2'd0;
  logic [14:0] pend_addr = '0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [14:0] b);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA0 + {17'd0, b + 15'(k)};
    return l;
  endfunction

  task automatic push_refill(input logic [14:0] b);
    for (int k = 0; k < 4; k++) exp_addr_q.push_back(b + 15'(k));
    exp_line_q.push_back(line_of(b));
  endtask

  // One clock: step to the negedge, run the memory model, then the monitor.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA0 + {17'd0, pend_addr};
        pend = 0;
      end else pend_cnt--;
    end
    if (spur_idle) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; end
    if (mem_rd === 1'b1) begin
      rd_seen++;
      last_rd_t = cyc_n;
      if (!(drop_en && mem_addr[1:0] == drop_k)) begin
        pend = 1; pend_cnt = mem_delay; pend_addr = mem_addr;
      end
      if (spur_issue) begin mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00; end
      if (exp_addr_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexp_rd: got read at %0h want none (cycle %0d)", mem_addr, cyc_n);
      end else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
    end
    if (line_valid === 1'b1) begin
      lv_seen++; lv_t = cyc_n;
      if (exp_line_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexp_lv: got line %0h want none (cycle %0d)", line_data, cyc_n);
      end else chk("line_data", line_data, exp_line_q.pop_front());
    end
    if (line_err === 1'b1) begin err_seen++; err_t = cyc_n; end
  endtask

  task automatic run_vec(input vec_t v);
    int t0, lv0, busy_lo;
    push_refill(v.exp_base);
    mem_delay = v.delay; spur_issue = v.spur;
    req = 1'b1; req_addr = v.addr;
    t0 = cyc_n; lv0 = lv_seen; busy_lo = 0;
    cyc();
    req = 1'b0; req_addr = v.addr ^ 15'h7FFC;  // moves to a different block while busy
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1) busy_lo++;
      if (lv_seen != lv0) break;
      cyc();
    end
    chk("latency", lv_t - t0, v.exp_lat);
    chk("busy_thru", busy_lo, 0);
    cyc();
    exp_cnt++;
    chk("busy_after", busy, 1'b0);
    chk("count", refill_count, exp_cnt);
    chk("lv_once", lv_seen - lv0, 1);
    spur_issue = 0;
  endtask

  initial begin
    int t0, lv0, e0, rd0, lv1_t, lv2_t, rd5_t;
    vecs[0] = '{15'h1236, 0, 15'h1234,  9, 1'b0};
    vecs[1] = '{15'h1236, 3, 15'h1234, 21, 1'b0};
    vecs[2] = '{15'h7FFF, 1, 15'h7FFC, 13, 1'b1};
    vecs[3] = '{15'h0001, 2, 15'h0000, 17, 1'b0};

    // Reset state
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 15'h0);
    chk("rst_line", line_data, 128'h0);
    chk("rst_lv", {line_valid, line_err}, 2'b00);
    chk("rst_count", refill_count, 16'h0);
    rst = 1'b0;
    cyc();

    // Spurious rvalid while idle is dropped
    spur_idle = 1;
    repeat (3) cyc();
    spur_idle = 0;
    cyc();
    chk("idle_spur_busy", busy, 1'b0);
    chk("idle_spur_line", line_data, 128'h0);

    // Table-driven refills
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("basic_line", line_data, 128'h000012D7_000012D6_000012D5_000012D4);
    end
    chk("line_hold", line_data, line_of(15'h0000));

    // Timeout on the third word
    drop_en = 1; drop_k = 2'd2; mem_delay = 0;
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(15'h2A58 + 15'(k));
    req = 1'b1; req_addr = 15'h2A5B;
    lv0 = lv_seen; e0 = err_seen;
    cyc();
    req = 1'b0;
    for (int i = 0; i < 100 && err_seen == e0; i++) cyc();
    chk("err_lat", err_t - last_rd_t, 17);
    chk("err_no_lv", lv_seen - lv0, 0);
    cyc();
    chk("err_once", err_seen - e0, 1);
    chk("err_busy", busy, 1'b0);
    chk("err_count", refill_count, exp_cnt);
    chk("err_partial", line_data,
        {line_of(15'h0000)[127:64], line_of(15'h2A58)[63:0]});
    drop_en = 0;

    // Reset during the WAIT for word 1
    mem_delay = 4;
    push_refill(15'h0564);
    req = 1'b1; req_addr = 15'h0567;
    rd0 = rd_seen;
    cyc();
    req = 1'b0;
    for (int i = 0; i < 50 && rd_seen < rd0 + 2; i++) cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_lv", line_valid, 1'b0);
    chk("mid_rst_count", refill_count, 16'h0);
    exp_addr_q.delete(); exp_line_q.delete(); pend = 0;
    lv0 = lv_seen; e0 = err_seen;
    cyc(); cyc();
    rst = 1'b0; exp_cnt = '0;
    cyc();
    chk("mid_rst_no_strobe", {lv_seen - lv0, err_seen - e0}, 64'h0);
    run_vec(vecs[0]);

    // Saturation with back-to-back refills (req held through DONE)
    force dut.refill_count_q = 16'hFFFE;
    #1 release dut.refill_count_q;
    push_refill(15'h1234); push_refill(15'h1234);
    mem_delay = 0;
    req = 1'b1; req_addr = 15'h1236;
    t0 = cyc_n; lv0 = lv_seen; rd0 = rd_seen;
    lv1_t = 0; lv2_t = 0; rd5_t = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (rd_seen == rd0 + 5 && rd5_t == 0) rd5_t = cyc_n;
      if (lv1_t != 0 && cyc_n == lv1_t + 1) chk("sat_count1", refill_count, 16'hFFFF);
      if (lv_seen == lv0 + 1 && lv1_t == 0) lv1_t = cyc_n;
      if (lv_seen == lv0 + 2) begin lv2_t = cyc_n; req = 1'b0; break; end
    end
    chk("b2b_lat1", lv1_t - t0, 9);
    chk("b2b_rd2", rd5_t - t0, 11);
    chk("b2b_lat2", lv2_t - t0, 19);
    cyc(); cyc();
    chk("sat_count2", refill_count, 16'hFFFF);
    chk("b2b_idle", busy, 1'b0);

    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("line_q_empty", exp_line_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
